// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver driven by an oversample enable: synchronizes rx, majority-votes
// three mid-bit samples per bit and hands finished bytes over through a valid/ack register.
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 10,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_en,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TICK_W-1:0]    tick_q, tick_d, tick_cur;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [1:0]           vote_q, vote_d;
    logic                 majority;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q;

    // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // tick_q holds the index of the last processed sample; the start-detect sample is tick 0.
    assign tick_cur = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    assign majority = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s_q) | (vote_q[0] & rx_s_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        vote_d  = vote_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (rx_ack && valid_q) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (sample_en && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START, S_DATA, S_STOP: begin
                if (sample_en) begin
                    tick_d = tick_cur;
                    if (tick_cur == TICK_PRE) vote_d[1] = rx_s_q;
                    if (tick_cur == TICK_MID) vote_d[0] = rx_s_q;

                    if (state_q == S_START) begin
                        if (tick_cur == TICK_VOTE && majority) begin
                            state_d = S_IDLE;
                            tick_d  = '0;
                        end else if (tick_cur == TICK_LAST) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end
                    end else if (state_q == S_DATA) begin
                        if (tick_cur == TICK_VOTE) begin
                            shift_d = {majority, shift_q[DATA_BITS-1:1]};
                        end
                        if (tick_cur == TICK_LAST) begin
                            if (bit_q == BIT_LAST) state_d = S_STOP;
                            else                   bit_d   = bit_q + 1'b1;
                        end
                    end else if (tick_cur == TICK_VOTE) begin
                        // Leave the stop bit early so a following start edge is caught promptly.
                        state_d = S_IDLE;
                        tick_d  = '0;
                        if (majority) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            ovr_d   = valid_q && !rx_ack;
                        end else begin
                            ferr_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            vote_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            vote_q  <= vote_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = busy_q;

endmodule
